// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NUM_REQ
// byte requesters. Sequences send -> tx_active_flag -> tx_done_flag for each byte
// and pulses ack to the owner when its byte has gone out.
// Optional watchdog: define UART_TX_ARB_TIMEOUT_EN to abort a transfer that has
// not completed TIMEOUT_CYC cycles after launch.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      send,
    output logic [DATA_W-1:0]         DATA_TX,
    input  logic                      tx_active_flag,
    input  logic                      tx_done_flag,
    output logic                      busy,
    output logic                      timeout
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_LAUNCH,
        S_WAIT_ACT,
        S_WAIT_DONE,
        S_RELEASE
    } state_e;

    state_e               state_q, state_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]     owner_q, owner_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 send_q, send_d;
    logic [DATA_W-1:0]    data_tx_q, data_tx_d;
    logic                 busy_q, busy_d;
    logic                 timeout_q, timeout_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
    logic [CNT_W-1:0]     cnt_q, cnt_d;
`endif

    logic                 win_valid;
    logic [PTR_W-1:0]     win_idx;

    // Round-robin pick: first asserted request scanning up from rr_ptr, wrapping.
    always_comb begin : arb_c
        logic [PTR_W-1:0] cand;
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = PTR_W'((32'(rr_ptr_q) + i) % NUM_REQ);
            if (!win_valid && req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state logic; outputs are a registered decode of the next state.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        data_tx_d = data_tx_q;
        timeout_d = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                // Never launch over a frame the UART is still shifting.
                if (win_valid && !tx_active_flag) begin
                    state_d   = S_GRANT;
                    owner_d   = win_idx;
                    data_tx_d = req_data[32'(win_idx)*DATA_W +: DATA_W];
                end
            end
            S_GRANT: state_d = S_LAUNCH;
            S_LAUNCH: begin
                state_d = S_WAIT_ACT;
`ifdef UART_TX_ARB_TIMEOUT_EN
                cnt_d   = CNT_W'(1);
`endif
            end
            S_WAIT_ACT, S_WAIT_DONE: begin
                // A done seen before active means a frame short enough to miss.
                if (tx_done_flag) begin
                    state_d = S_RELEASE;
                end else begin
                    if (state_q == S_WAIT_ACT && tx_active_flag) begin
                        state_d = S_WAIT_DONE;
                    end
`ifdef UART_TX_ARB_TIMEOUT_EN
                    if (cnt_q >= CNT_W'(TIMEOUT_CYC - 1)) begin
                        state_d   = S_RELEASE;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`endif
                end
            end
            S_RELEASE: begin
                state_d  = S_IDLE;
                rr_ptr_d = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
            end
            default: state_d = S_IDLE;
        endcase

        send_d = (state_d == S_LAUNCH);
        busy_d = (state_d != S_IDLE);
        gnt_d  = '0;
        ack_d  = '0;
        if (state_d == S_GRANT || state_d == S_LAUNCH ||
            state_d == S_WAIT_ACT || state_d == S_WAIT_DONE) begin
            gnt_d = NUM_REQ'(1) << owner_d;
        end
        if (state_d == S_RELEASE) begin
            ack_d = NUM_REQ'(1) << owner_d;
        end
    end

    // State and output registers; reset abandons any transfer without an ack.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            gnt_q     <= '0;
            ack_q     <= '0;
            send_q    <= 1'b0;
            data_tx_q <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            gnt_q     <= gnt_d;
            ack_q     <= ack_d;
            send_q    <= send_d;
            data_tx_q <= data_tx_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign ack     = ack_q;
    assign send    = send_q;
    assign DATA_TX = data_tx_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (4 requesters, 8-bit data, TIMEOUT_CYC=16).
module tb_uart_tx_arbiter;

    localparam int unsigned NUM_REQ     = 4;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned TIMEOUT_CYC = 16;

    logic                      PCLK = 1'b0;
    logic                      PRESET;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        ack;
    logic [NUM_REQ-1:0]        gnt;
    logic                      send;
    logic [DATA_W-1:0]         DATA_TX;
    logic                      tx_active_flag;
    logic                      tx_done_flag;
    logic                      busy;
    logic                      timeout;

    int n_checks   = 0;
    int n_errors   = 0;
    int ack_pulses = 0;
    int exp_acks   = 0;

    uart_tx_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_W     (DATA_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .PCLK          (PCLK),
        .PRESET        (PRESET),
        .req           (req),
        .req_data      (req_data),
        .ack           (ack),
        .gnt           (gnt),
        .send          (send),
        .DATA_TX       (DATA_TX),
        .tx_active_flag(tx_active_flag),
        .tx_done_flag  (tx_done_flag),
        .busy          (busy),
        .timeout       (timeout)
    );

    always #5 PCLK = ~PCLK;

    // Count every ack bit seen over the whole run.
    always @(posedge PCLK) ack_pulses += $countones(ack);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic wait_send(input string tag);
        int k = 0;
        while (send !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check(tag, 32'(send), 32'd1);
    endtask

    // One byte with a cooperative UART: active for act_cycles, then a done pulse.
    task automatic do_frame(input string tag, input int act_cycles,
                            input logic [3:0] exp_gnt, input logic [7:0] exp_data);
        wait_send({tag, "_send"});
        check({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
        check({tag, "_data"}, 32'(DATA_TX), 32'(exp_data));
        tick();
        tx_active_flag = 1'b1;
        repeat (act_cycles) tick();
        tx_active_flag = 1'b0;
        tx_done_flag   = 1'b1;
        tick();
        tx_done_flag   = 1'b0;
        check({tag, "_ack"}, 32'(ack), 32'(exp_gnt));
        check({tag, "_gnt_rel"}, 32'(gnt), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        PRESET         = 1'b1;
        req            = '0;
        req_data       = 32'h4433_5A11;
        tx_active_flag = 1'b0;
        tx_done_flag   = 1'b0;
        tick();
        tick();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_send", 32'(send), 32'd0);
        check("rst_data", 32'(DATA_TX), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        PRESET = 1'b0;
        tick();

        // Single request, exact launch latency and done 10 cycles after send.
        req = 4'b0010;
        tick();
        check("t1_grant_gnt", 32'(gnt), 32'h2);
        check("t1_grant_data", 32'(DATA_TX), 32'h5A);
        check("t1_grant_send", 32'(send), 32'd0);
        check("t1_grant_busy", 32'(busy), 32'd1);
        tick();
        check("t1_send", 32'(send), 32'd1);
        tick();
        check("t1_send_pulse", 32'(send), 32'd0);
        tx_active_flag = 1'b1;
        repeat (8) tick();
        check("t1_no_early_ack", 32'(ack), 32'd0);
        tx_active_flag = 1'b0;
        tx_done_flag   = 1'b1;
        tick();
        tx_done_flag   = 1'b0;
        check("t1_ack", 32'(ack), 32'h2);
        check("t1_rel_gnt", 32'(gnt), 32'd0);
        req = 4'b0000;
        tick();
        check("t1_ack_pulse", 32'(ack), 32'd0);
        check("t1_idle_busy", 32'(busy), 32'd0);
        exp_acks += 1;

        // Round robin from rr_ptr=0 with all four requesting.
        PRESET = 1'b1;
        tick();
        PRESET   = 1'b0;
        req_data = 32'h4433_2211;
        req      = 4'b1111;
        do_frame("rr0", 3, 4'b0001, 8'h11);
        tick();
        check("rr_gap_busy", 32'(busy), 32'd0);
        do_frame("rr1", 2, 4'b0010, 8'h22);
        do_frame("rr2", 4, 4'b0100, 8'h33);
        do_frame("rr3", 1, 4'b1000, 8'h44);
        do_frame("rr4", 2, 4'b0001, 8'h11);
        req = 4'b0000;
        tick();
        exp_acks += 5;

        // Put rr_ptr at 3, then 3 and 0 held: must wrap and alternate.
        req = 4'b0100;
        do_frame("wr_set", 1, 4'b0100, 8'h33);
        req = 4'b1001;
        do_frame("wr_a", 1, 4'b1000, 8'h44);
        do_frame("wr_b", 1, 4'b0001, 8'h11);
        do_frame("wr_c", 1, 4'b1000, 8'h44);
        req = 4'b0000;
        tick();
        exp_acks += 4;

        // UART still shifting while idle: arbitration must hold off.
        tx_active_flag = 1'b1;
        req            = 4'b0001;
        repeat (3) tick();
        check("act_hold_busy", 32'(busy), 32'd0);
        check("act_hold_gnt", 32'(gnt), 32'd0);
        tx_active_flag = 1'b0;
        do_frame("act_rel", 2, 4'b0001, 8'h11);
        req = 4'b0000;
        tick();
        exp_acks += 1;

        // tx_done_flag held 3 cycles with no active phase: one ack, no relaunch.
        req = 4'b0010;
        wait_send("dh_send");
        tick();
        tx_done_flag = 1'b1;
        tick();
        check("dh_ack", 32'(ack), 32'h2);
        req = 4'b0000;
        tick();
        check("dh_ack_once", 32'(ack), 32'd0);
        check("dh_no_send1", 32'(send), 32'd0);
        tick();
        tx_done_flag = 1'b0;
        check("dh_no_send2", 32'(send), 32'd0);
        check("dh_idle", 32'(busy), 32'd0);
        tick();
        exp_acks += 1;

        // Reset in WAIT_DONE: immediate abort, no ack, rr_ptr back to 0.
        req = 4'b0100;
        wait_send("rs_send");
        check("rs_gnt", 32'(gnt), 32'h4);
        tick();
        tx_active_flag = 1'b1;
        tick();
        PRESET = 1'b1;
        #1;
        check("rs_gnt0", 32'(gnt), 32'd0);
        check("rs_busy0", 32'(busy), 32'd0);
        tick();
        check("rs_send0", 32'(send), 32'd0);
        check("rs_no_ack", 32'(ack), 32'd0);
        PRESET         = 1'b0;
        tx_active_flag = 1'b0;
        req            = 4'b0101;
        do_frame("rs_rearb", 2, 4'b0001, 8'h11);
        req = 4'b0000;
        tick();
        exp_acks += 1;

        // UART never responds.
        req = 4'b0010;
        wait_send("to_send");
`ifdef UART_TX_ARB_TIMEOUT_EN
        repeat (15) tick();
        check("to_early_ack", 32'(ack), 32'd0);
        check("to_early_tmo", 32'(timeout), 32'd0);
        tick();
        check("to_ack", 32'(ack), 32'h2);
        check("to_tmo", 32'(timeout), 32'd1);
        check("to_gnt", 32'(gnt), 32'd0);
        req = 4'b0000;
        tick();
        check("to_tmo_pulse", 32'(timeout), 32'd0);
        check("to_idle", 32'(busy), 32'd0);
        exp_acks += 1;
`else
        repeat (40) tick();
        check("nt_stuck_busy", 32'(busy), 32'd1);
        check("nt_tmo", 32'(timeout), 32'd0);
        check("nt_no_ack", 32'(ack), 32'd0);
        req    = 4'b0000;
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0;
`endif
        tick();
        tick();
        check("ack_total", 32'(ack_pulses), 32'(exp_acks));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
